// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetch and MEM load/store.
// Optional macro ARB_TIMEOUT_EN aborts accesses that never see mem_ack.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                bus_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] streak;
  logic          if_elig;
  logic          dm_elig;
  logic          grant_if;
  logic          grant_dm;
  logic          done_if;
  logic          done_dm;
  logic          tmo;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  // a req still high during its own valid pulse is the old request
  assign if_elig = if_req & ~if_valid;
  assign dm_elig = dm_req & ~dm_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (grant_if)      state_nx = BUSY_IF;
        else if (grant_dm) state_nx = BUSY_DM;
      end
      BUSY_IF: if (done_if) state_nx = IDLE;
      BUSY_DM: if (done_dm) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    done_if  = 1'b0;
    done_dm  = 1'b0;
    unique case (state)
      IDLE: begin
        grant_dm = dm_elig & (~if_elig | (streak != SMAX));
        grant_if = if_elig & ~grant_dm;
      end
      BUSY_IF: done_if = mem_ack | tmo;
      BUSY_DM: done_dm = mem_ack | tmo;
      default: ;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         tcnt <= '0;
    else if (state == IDLE || mem_ack) tcnt <= '0;
    else                              tcnt <= tcnt + TW'(1);
  end

  assign tmo = (state != IDLE) & ~mem_ack &
               (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     bus_err <= 1'b0;
    else if (tmo) bus_err <= 1'b1;
  end
`else
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      streak    <= '0;
    end else begin
      if_valid <= done_if;
      dm_valid <= done_dm;
      if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end else if (grant_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
      end else if (done_if | done_dm) begin
        mem_req   <= 1'b0;
      end
      if (done_if)
        if_rdata <= tmo ? '0 : mem_rdata;
      // stores keep the last load data unless aborted
      if (done_dm & (tmo | ~mem_we))
        dm_rdata <= tmo ? '0 : mem_rdata;
      if (grant_if)
        streak <= '0;
      else if (state == IDLE && !if_req)
        streak <= '0;
      else if (grant_dm && if_req && streak != SMAX)
        streak <= streak + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: reset table, directed sequences and a random run
// checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int STARVE  = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: owner 0 = none, 1 = fetch, 2 = data
  int          m_owner;
  int          m_streak;
  int          m_busy;
  logic        m_mem_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_if_valid;
  logic        m_dm_valid;
  logic [31:0] m_if_rdata;
  logic [31:0] m_dm_rdata;
  logic        m_bus_err;

  typedef struct {
    logic ir;
    logic dr;
    logic ack;
    logic e_si;
    logic e_sm;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner    = 0;
    m_streak   = 0;
    m_busy     = 0;
    m_mem_req  = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_be       = '0;
    m_if_valid = 1'b0;
    m_dm_valid = 1'b0;
    m_if_rdata = '0;
    m_dm_rdata = '0;
    m_bus_err  = 1'b0;
  endtask

  task automatic finish_access(input logic [31:0] data, input bit abort);
    if (m_owner == 1) begin
      m_if_valid = 1'b1;
      m_if_rdata = data;
    end else begin
      m_dm_valid = 1'b1;
      if (!m_we || abort) m_dm_rdata = data;
    end
    m_mem_req = 1'b0;
    m_owner   = 0;
  endtask

  // advances the model across one rising edge using current inputs
  task automatic model_step();
    bit ie, de, gi, gd;
    if (!rst) begin
      model_reset();
      return;
    end
    ie = if_req && !m_if_valid;
    de = dm_req && !m_dm_valid;
    m_if_valid = 1'b0;
    m_dm_valid = 1'b0;
    if (m_owner == 0) begin
      gd = de && (!ie || m_streak != STARVE);
      gi = ie && !gd;
      if (gi || !if_req) m_streak = 0;
      else if (gd && m_streak < STARVE) m_streak++;
      m_busy = 0;
      if (gi) begin
        m_owner = 1; m_mem_req = 1'b1; m_we = 1'b0;
        m_addr = if_addr; m_be = 4'hf;
      end else if (gd) begin
        m_owner = 2; m_mem_req = 1'b1; m_we = dm_we;
        m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_be;
      end
    end else begin
      m_busy++;
      if (mem_ack) finish_access(mem_rdata, 1'b0);
`ifdef ARB_TIMEOUT_EN
      else if (m_busy == TIMEOUT) begin
        finish_access('0, 1'b1);
        m_bus_err = 1'b1;
      end
`endif
    end
  endtask

  task automatic check_all();
    chk("mem_req", mem_req, m_mem_req);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_be", mem_be, m_be);
    if (m_owner == 2) chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_valid", if_valid, m_if_valid);
    chk("dm_valid", dm_valid, m_dm_valid);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
    chk("stall_if", stall_if, if_req & ~m_if_valid);
    chk("stall_mem", stall_mem, dm_req & ~m_dm_valid);
    chk("bus_err", bus_err, m_bus_err);
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_grant(input string nm);
    int n = 0;
    while (!m_mem_req && n < 10) begin
      step();
      n++;
    end
    if (!m_mem_req) chk(nm, 32'd0, 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_addr[6];
  int          cnt;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h40; dm_addr = 32'h200; dm_wdata = '0; dm_be = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    @(negedge clk);

    // reset state table: nothing but the combinational stalls moves
    for (int i = 0; i < 5; i++) begin
      if_req = tbl[i].ir; dm_req = tbl[i].dr; mem_ack = tbl[i].ack;
      @(negedge clk);
      chk("rst_stall_if", stall_if, tbl[i].e_si);
      chk("rst_stall_mem", stall_mem, tbl[i].e_sm);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_if_valid", if_valid, 1'b0);
      chk("rst_dm_valid", dm_valid, 1'b0);
      chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_bus_err", bus_err, 1'b0);
    end

    // release with both requests pending: data side wins
    if_req = 1'b1; dm_req = 1'b1; mem_ack = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    chk("rel_mem_req", mem_req, 1'b1);
    chk("rel_mem_addr", mem_addr, 32'h200);
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    chk("rel_dm_valid", dm_valid, 1'b1);
    chk("rel_dm_rdata", dm_rdata, 32'h1111_1111);
    mem_ack = 1'b0; dm_req = 1'b0;
    step();

    // lone fetch
    if_req = 1'b1; if_addr = 32'h40;
    step();
    chk("f_mem_req", mem_req, 1'b1);
    chk("f_mem_addr", mem_addr, 32'h40);
    chk("f_mem_be", mem_be, 4'hf);
    chk("f_mem_we", mem_we, 1'b0);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    step();
    chk("f_if_valid", if_valid, 1'b1);
    chk("f_if_rdata", if_rdata, 32'h0050_0093);
    chk("f_stall_if", stall_if, 1'b0);
    mem_ack = 1'b0; if_req = 1'b0;
    step();
    chk("f_if_valid_1cyc", if_valid, 1'b0);

    // store; inputs changed after grant must not leak through
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100;
    dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
    step();
    chk("s_mem_we", mem_we, 1'b1);
    chk("s_mem_addr", mem_addr, 32'h100);
    chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("s_mem_be", mem_be, 4'b0011);
    dm_addr = 32'hFFF0; dm_wdata = '0; dm_be = 4'hf;
    step();
    chk("s_addr_hold", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    chk("s_dm_valid", dm_valid, 1'b1);
    chk("s_dm_rdata_kept", dm_rdata, 32'h1111_1111);
    mem_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    step();

    // both held: a requester is ineligible in its own valid cycle
    if_addr = 32'h40; dm_addr = 32'h300;
    if_req = 1'b1; dm_req = 1'b1;
    for (int g = 0; g < 6; g++) exp_addr[g] = g[0] ? 32'h40 : 32'h300;
    for (int g = 0; g < 6; g++) begin
      wait_grant("arb_grant_wait");
      chk("arb_order", mem_addr, exp_addr[g]);
      mem_ack = 1'b1; mem_rdata = 32'h100 + 32'(g);
      if (g == 5) begin if_req = 1'b1; dm_req = 1'b1; end
      step();
      mem_ack = 1'b0;
      if (g == 5) begin if_req = 1'b0; dm_req = 1'b0; end
    end
    step();

    // reset in the middle of a data access
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h380;
    step();
    chk("mr_busy", mem_req, 1'b1);
    step();
    rst = 1'b0; dm_req = 1'b0;
    model_reset();
    #1;
    chk("mr_mem_req_drop", mem_req, 1'b0);
    check_all();
    @(negedge clk);
    mem_ack = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("mr_no_valid", dm_valid, 1'b0);
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mr_no_valid", dm_valid, 1'b0);
    end

`ifdef ARB_TIMEOUT_EN
    if_req = 1'b1; if_addr = 32'h44;
    cnt = 0;
    step();
    for (int n = 0; n < 40 && !if_valid; n++) begin
      if (mem_req) cnt++;
      step();
    end
    chk("to_req_cycles", cnt, TIMEOUT);
    chk("to_if_valid", if_valid, 1'b1);
    chk("to_if_rdata", if_rdata, 32'd0);
    chk("to_bus_err", bus_err, 1'b1);
    if_req = 1'b0;
    step(); step();
    chk("to_bus_err_sticky", bus_err, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("to_bus_err_clr", bus_err, 1'b0);
`endif

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) != 0);
      if (!if_req || m_if_valid) if_req = ($urandom_range(0, 2) != 0);
      if_addr = $urandom;
      if (!dm_req || m_dm_valid) dm_req = ($urandom_range(0, 2) != 0);
      dm_we    = $urandom_range(0, 1) != 0;
      dm_addr  = $urandom;
      dm_wdata = $urandom;
      dm_be    = 4'($urandom_range(0, 15));
      mem_rdata = $urandom;
      mem_ack = m_mem_req ? ($urandom_range(0, 2) == 0)
                          : ($urandom_range(0, 7) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
